// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding and
// the pattern-length legality check used when a new configuration is loaded.
package seq_det_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    function automatic logic len_ok(input int unsigned len, input int unsigned max);
        return (len >= 1) && (len <= max);
    endfunction

endpackage

// File: rtl/seq_det_cmp.sv
// Combinational masked compare: true when the low `len` bits of hist equal the
// low `len` bits of pat. Bits at or above len are ignored.
module seq_det_cmp #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5
) (
    input  logic [MAX_LEN-1:0] hist,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    output logic               eq
);

    logic [MAX_LEN-1:0] mask;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < 32'(len));
        end
        eq = (((hist ^ pat) & mask) == '0);
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with overlap/non-overlap modes.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               res,
    input  logic               seq,
    input  logic               seq_vld,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    output logic               match,
    output logic               cfg_err,
    output logic               armed,
    output logic [CNT_W-1:0]   match_cnt
);

    logic               state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    // Newest bit comes straight from seq, so only MAX_LEN-1 older bits are stored.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;
    logic               err_q, err_d;

    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic               eq, hit, cfg_legal, shift_en;

    assign hist_next = {hist_q, seq};
    assign fill_next = (fill_q >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill_q + 1'b1;
    assign cfg_legal = len_ok(32'(pat_len), MAX_LEN);
    assign shift_en  = (state_q == ST_RUN) && seq_vld && !cfg_load;
    assign hit       = shift_en && (fill_next >= len_q) && eq;

    seq_det_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .hist (hist_next),
        .pat  (pat_q),
        .len  (len_q),
        .eq   (eq)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        err_d   = err_q;
        if (cfg_load) begin
            // A bit arriving alongside cfg_load is dropped.
            if (cfg_legal) begin
                state_d = ST_RUN;
                pat_d   = pat;
                len_d   = pat_len;
                ovl_d   = overlap;
                hist_d  = '0;
                fill_d  = '0;
                err_d   = 1'b0;
            end else begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end
        end else if (shift_en) begin
            hist_d  = hist_next[MAX_LEN-2:0];
            fill_d  = (hit && !ovl_q) ? '0 : fill_next;
            match_d = hit;
        end
    end

    always_comb begin
        match   = match_q;
        cfg_err = err_q;
        armed   = (state_q == ST_RUN);
    end

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector against a queue-based reference model.
module tb_seq_pattern_detector;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               res;
    logic               seq, seq_vld, cfg_load, overlap;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   pat_len;
    logic               match, cfg_err, armed;
    logic [CNT_W-1:0]   match_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state: received bits since last restart, newest at the back.
    bit m_q[$];
    bit m_armed, m_err, m_match, m_ovl;
    bit [MAX_LEN-1:0] m_pat;
    int m_len;
    int m_cnt;

    seq_pattern_detector #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .res       (res),
        .seq       (seq),
        .seq_vld   (seq_vld),
        .cfg_load  (cfg_load),
        .pat       (pat),
        .pat_len   (pat_len),
        .overlap   (overlap),
        .match     (match),
        .cfg_err   (cfg_err),
        .armed     (armed),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    function automatic int exp_cnt();
`ifdef SEQ_DET_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_armed = 0;
        m_err   = 0;
        m_match = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        bit hit;
        if (cfg_load) begin
            m_match = 0;
            if (pat_len >= 1 && pat_len <= MAX_LEN) begin
                m_armed = 1;
                m_err   = 0;
                m_pat   = pat;
                m_len   = int'(pat_len);
                m_ovl   = overlap;
                m_q.delete();
            end else begin
                m_armed = 0;
                m_err   = 1;
            end
        end else if (m_armed && seq_vld) begin
            m_q.push_back(seq);
            if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
            hit = (m_q.size() >= m_len);
            for (int i = 0; i < m_len; i++) begin
                if (hit && m_q[m_q.size() - 1 - i] != m_pat[i]) hit = 0;
            end
            m_match = hit;
            if (hit && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (hit && !m_ovl) m_q.delete();
        end else begin
            m_match = 0;
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle 1 time unit.
    task automatic cycle(input logic s, input logic v, input logic c);
        seq      = s;
        seq_vld  = v;
        cfg_load = c;
        @(posedge clk);
        model_step();
        #1;
        seq_vld  = 1'b0;
        cfg_load = 1'b0;
    endtask

    task automatic configure(input logic [MAX_LEN-1:0] p, input int l, input logic o);
        pat     = p;
        pat_len = LEN_W'(l);
        overlap = o;
        cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        res = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        res = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (match !== 1'b0 || armed !== 1'b0 || cfg_err !== 1'b0 || match_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: match=%b armed=%b cfg_err=%b cnt=%0d, want all 0",
                     match, armed, cfg_err, match_cnt);
        end
        configure(16'b11, 2, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (match !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_match: match=%b want 1", match);
        end
        // Async assertion between edges while the pulse is high.
        #1 res = 1'b0;
        model_reset();
        #1;
        checks++;
        if (match !== 1'b0 || armed !== 1'b0 || cfg_err !== 1'b0 || match_cnt !== '0) begin
            errors++;
            $display("FAIL reset_async: match=%b armed=%b cfg_err=%b cnt=%0d, want all 0",
                     match, armed, cfg_err, match_cnt);
        end
        #1 res = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'(i & 1), 1'b1, 1'b0);
            checks++;
            if (match !== 1'b0 || armed !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_ignore[%0d]: match=%b armed=%b want 0/0",
                         i, match, armed);
            end
        end
    endtask

    task automatic run_10011(input logic o, input string name);
        bit stream[9] = '{1, 0, 0, 1, 1, 0, 0, 1, 1};
        bit want;
        do_reset();
        configure(16'b10011, 5, o);
        for (int i = 0; i < 9; i++) begin
            cycle(stream[i], 1'b1, 1'b0);
            want = (i == 4) || (o && i == 8);
            checks++;
            if (match !== want || match !== m_match) begin
                errors++;
                $display("FAIL %s_bit%0d: match=%b want %b (model %b)",
                         name, i + 1, match, want, m_match);
            end
        end
        checks++;
        if (int'(match_cnt) !== exp_cnt()) begin
            errors++;
            $display("FAIL %s_cnt: match_cnt=%0d want %0d", name, match_cnt, exp_cnt());
        end
    endtask

    task automatic test_overlap();
        run_10011(1'b1, "overlap");
    endtask

    task automatic test_non_overlap();
        run_10011(1'b0, "non_overlap");
    endtask

    task automatic test_illegal();
        int lens[2] = '{0, MAX_LEN + 1};
        do_reset();
        foreach (lens[k]) begin
            configure(16'hFFFF, lens[k], 1'b1);
            checks++;
            if (cfg_err !== 1'b1 || armed !== 1'b0) begin
                errors++;
                $display("FAIL illegal_len%0d: cfg_err=%b armed=%b want 1/0",
                         lens[k], cfg_err, armed);
            end
            for (int i = 0; i < 20; i++) begin
                cycle(1'b1, 1'b1, 1'b0);
                checks++;
                if (match !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_nomatch_len%0d[%0d]: match=%b want 0",
                             lens[k], i, match);
                end
            end
        end
        configure(16'b101, 3, 1'b0);
        checks++;
        if (cfg_err !== 1'b0 || armed !== 1'b1) begin
            errors++;
            $display("FAIL illegal_recover: cfg_err=%b armed=%b want 0/1", cfg_err, armed);
        end
    endtask

    task automatic test_gaps_reload();
        bit bits[4] = '{1, 0, 1, 1};
        do_reset();
        configure(16'b1011, 4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < i; g++) begin
                cycle(1'(g & 1), 1'b0, 1'b0);
                checks++;
                if (match !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_idle[%0d.%0d]: match=%b want 0", i, g, match);
                end
            end
            cycle(bits[i], 1'b1, 1'b0);
            checks++;
            if (match !== (i == 3) || match !== m_match) begin
                errors++;
                $display("FAIL gap_bit%0d: match=%b want %b", i + 1, match, (i == 3));
            end
        end
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        // Third bit rides with cfg_load and is discarded along with history.
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (match !== 1'b0 || match !== m_match) begin
            errors++;
            $display("FAIL reload_clears: match=%b want 0", match);
        end
    endtask

    task automatic test_limits();
        int first = 0;
        int n = 0;
        do_reset();
        configure(16'hFFFF, MAX_LEN, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (match === 1'b1) begin
                n++;
                if (first == 0) first = i;
            end
            checks++;
            if (match !== (i >= MAX_LEN) || match !== m_match) begin
                errors++;
                $display("FAIL limits_bit%0d: match=%b want %b", i, match, (i >= MAX_LEN));
            end
        end
        checks++;
        if (first != MAX_LEN || n != 300 - MAX_LEN + 1) begin
            errors++;
            $display("FAIL limits_first: first=%0d count=%0d want %0d/%0d",
                     first, n, MAX_LEN, 300 - MAX_LEN + 1);
        end
        checks++;
`ifdef SEQ_DET_CNT_EN
        if (match_cnt !== 8'd255) begin
            errors++;
            $display("FAIL limits_sat: match_cnt=%0d want 255", match_cnt);
        end
`else
        if (match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL limits_nocnt: match_cnt=%0d want 0", match_cnt);
        end
`endif
    endtask

    task automatic test_random();
        int l;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0 || i == 0) begin
                l = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : MAX_LEN + 1)
                                                : int'($urandom_range(1, 5));
                pat     = MAX_LEN'($urandom);
                pat_len = LEN_W'(l);
                overlap = 1'($urandom_range(0, 1));
                cycle(1'($urandom), 1'($urandom), 1'b1);
            end else begin
                cycle(1'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
            end
            checks++;
            if (match !== m_match || armed !== m_armed || cfg_err !== m_err ||
                int'(match_cnt) !== exp_cnt()) begin
                errors++;
                $display("FAIL random[%0d]: match=%b armed=%b err=%b cnt=%0d want %b %b %b %0d",
                         i, match, armed, cfg_err, match_cnt, m_match, m_armed, m_err,
                         exp_cnt());
            end
        end
    endtask

    initial begin
        res      = 1'b0;
        seq      = 1'b0;
        seq_vld  = 1'b0;
        cfg_load = 1'b0;
        pat      = '0;
        pat_len  = '0;
        overlap  = 1'b0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_illegal();
        test_gaps_reload();
        test_limits();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
